// File: rtl/div_if.sv
// Execute-stage divider port bundle: request/operand side driven by execute,
// result/status side driven by the divider.
interface div_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic             is_flush;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             busy;

  modport master (
    output en, is_flush, is_signed, a, b,
    input  quotient, remainder, done, busy
  );

  modport slave (
    input  en, is_flush, is_signed, a, b,
    output quotient, remainder, done, busy
  );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider (signed/unsigned). It works on magnitudes and
// retires BITS_PER_CYCLE quotient bits per cycle, fixing up the signs on write.
module div_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  div_if.slave bus
);

  localparam int              N    = WIDTH / BITS_PER_CYCLE;
  localparam int              CW   = $clog2(N) + 1;
  localparam logic [CW-1:0]   LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;       // dividend magnitude, shifts out as quotient shifts in
  logic [WIDTH-1:0] dvs;       // divisor magnitude
  logic [WIDTH-1:0] rem;       // partial remainder
  logic             q_neg;
  logic             r_neg;
  logic             div_zero;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;

  logic [WIDTH-1:0] dvd_nx, rem_nx;
  logic [WIDTH:0]   shifted, diff;
  logic             sa, sb;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign sa    = bus.is_signed & bus.a[WIDTH-1];
  assign sb    = bus.is_signed & bus.b[WIDTH-1];
  // 100..0 negates to itself and is then read as the unsigned 2^(WIDTH-1).
  assign abs_a = sa ? -bus.a : bus.a;
  assign abs_b = sb ? -bus.b : bus.b;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: every output of a combinational block is given a default first, so
  // no path through the case leaves it unassigned and a latch cannot be inferred.
  always_comb begin
    state_nx = state;
    bus.done = 1'b0;
    bus.busy = (state != IDLE);
    unique case (state)
      IDLE:    if (bus.en) state_nx = (bus.b == '0) ? DONE : CALC;
      CALC:    if (cnt == LAST) state_nx = DONE;
      DONE: begin
        state_nx = IDLE;
        bus.done = ~bus.is_flush;
      end
      default: state_nx = IDLE;
    endcase
    if (bus.is_flush) state_nx = IDLE;
  end

  // BITS_PER_CYCLE chained restoring steps per CALC cycle.
  always_comb begin
    rem_nx  = rem;
    dvd_nx  = dvd;
    shifted = '0;
    diff    = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      shifted = {rem_nx, dvd_nx[WIDTH-1]};
      diff    = shifted - {1'b0, dvs};
      dvd_nx  = {dvd_nx[WIDTH-2:0], ~diff[WIDTH]};
      rem_nx  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: the working registers are reset along with the results; there is
  // no memory array here, so clearing them costs only a few gates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      div_zero    <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.en && !bus.is_flush) begin
          cnt      <= '0;
          dvd      <= abs_a;
          dvs      <= abs_b;
          rem      <= '0;
          q_neg    <= sa ^ sb;
          r_neg    <= sa;
          div_zero <= (bus.b == '0);
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          dvd <= dvd_nx;
          rem <= rem_nx;
        end
        DONE: if (!bus.is_flush) begin
          // Divide by zero: dvd still holds |a|, and r_neg restores a exactly.
          quotient_q  <= div_zero ? '1 : (q_neg ? -dvd : dvd);
          remainder_q <= div_zero ? (r_neg ? -dvd : dvd) : (r_neg ? -rem : rem);
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: one BITS_PER_CYCLE=1 and one BITS_PER_CYCLE=2 instance,
// checked against a reference divider through an expected-result queue.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  div_if #(.WIDTH(32)) i1 ();
  div_if #(.WIDTH(32)) i2 ();

  div_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_bpc1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
  div_unit #(.WIDTH(32), .BITS_PER_CYCLE(2)) u_bpc2 (.clk(clk), .rst_n(rst_n), .bus(i2.slave));

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic set_in(input int sel, input logic en, input logic fl, input logic s,
                        input logic [31:0] a, input logic [31:0] b);
    if (sel == 1) begin
      i1.en = en; i1.is_flush = fl; i1.is_signed = s; i1.a = a; i1.b = b;
    end else begin
      i2.en = en; i2.is_flush = fl; i2.is_signed = s; i2.a = a; i2.b = b;
    end
  endtask

  function automatic logic [31:0] get_q(input int sel);
    return (sel == 1) ? i1.quotient : i2.quotient;
  endfunction
  function automatic logic [31:0] get_r(input int sel);
    return (sel == 1) ? i1.remainder : i2.remainder;
  endfunction
  function automatic logic get_done(input int sel);
    return (sel == 1) ? i1.done : i2.done;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 1) ? i1.busy : i2.busy;
  endfunction

  // Reference divider on 64-bit signed ints; % follows the dividend's sign.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Starts one operation from a negedge in IDLE and checks busy/done each
  // cycle; flush_at > 0 flushes (with en also high) in that cycle instead.
  // Ends on the negedge of the cycle after done, so a caller can chain ops.
  task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int flush_at, input string name);
    exp_t        e;
    logic [31:0] old_q, old_r;
    int          lat;
    ref_div(a, b, s, e.q, e.r);
    sb_q.push_back(e);
    lat   = (b == 32'd0) ? 1 : ((sel == 1) ? 33 : 17);
    old_q = get_q(sel);
    old_r = get_r(sel);
    set_in(sel, 1'b1, 1'b0, s, a, b);
    for (int cyc = 1; cyc <= lat; cyc++) begin
      @(negedge clk);
      // Garbage operands and stray en while busy must be ignored.
      set_in(sel, (cyc < lat) ? 1'($urandom) : 1'b0, 1'b0, 1'($urandom), $urandom, $urandom);
      if (cyc == flush_at) begin
        set_in(sel, 1'b1, 1'b1, s, a, b);
        #1;
        checks++;
        if (get_done(sel) !== 1'b0) begin
          errors++;
          $display("FAIL %s flush_done_cyc%0d: done=%b required 0", name, cyc, get_done(sel));
        end
        @(negedge clk);
        set_in(sel, 1'b0, 1'b0, 1'b0, '0, '0);
        checks++;
        if (get_busy(sel) !== 1'b0 || get_done(sel) !== 1'b0) begin
          errors++;
          $display("FAIL %s flush_idle: busy=%b done=%b required 0 0", name,
                   get_busy(sel), get_done(sel));
        end
        checks++;
        if (get_q(sel) !== old_q || get_r(sel) !== old_r) begin
          errors++;
          $display("FAIL %s flush_hold: q=%h r=%h required q=%h r=%h", name,
                   get_q(sel), get_r(sel), old_q, old_r);
        end
        void'(sb_q.pop_back());
        return;
      end
      checks++;
      if (get_busy(sel) !== 1'b1) begin
        errors++;
        $display("FAIL %s busy_cyc%0d: busy=%b required 1", name, cyc, get_busy(sel));
      end
      checks++;
      if (get_done(sel) !== (cyc == lat)) begin
        errors++;
        $display("FAIL %s done_cyc%0d: done=%b required %b", name, cyc, get_done(sel), cyc == lat);
      end
    end
    e = sb_q.pop_front();
    @(negedge clk);
    checks++;
    if (get_busy(sel) !== 1'b0 || get_done(sel) !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: busy=%b done=%b required 0 0", name, get_busy(sel), get_done(sel));
    end
    checks++;
    if (get_q(sel) !== e.q || get_r(sel) !== e.r) begin
      errors++;
      $display("FAIL %s result: a=%h b=%h s=%b q=%h r=%h required q=%h r=%h", name, a, b, s,
               get_q(sel), get_r(sel), e.q, e.r);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    set_in(1, 1'b0, 1'b0, 1'b0, '0, '0);
    set_in(2, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    for (int sel = 1; sel <= 2; sel++) begin
      checks++;
      if (get_q(sel) !== 32'd0 || get_r(sel) !== 32'd0 || get_done(sel) !== 1'b0 ||
          get_busy(sel) !== 1'b0) begin
        errors++;
        $display("FAIL reset_state dut%0d: q=%h r=%h done=%b busy=%b required all 0", sel,
                 get_q(sel), get_r(sel), get_done(sel), get_busy(sel));
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned;
    run_op(1, 32'd100, 32'd7, 1'b0, -1, "unsigned_100_7");
    run_op(1, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0, -1, "unsigned_max_3");
  endtask

  task automatic test_signed;
    run_op(1, 32'hFFFF_FFF9, 32'd2, 1'b1, -1, "signed_m7_2");
    run_op(1, 32'd7, 32'hFFFF_FFFE, 1'b1, -1, "signed_7_m2");
    run_op(1, 32'hFFFF_FFF8, 32'hFFFF_FFFE, 1'b1, -1, "signed_m8_m2");
  endtask

  task automatic test_corner;
    run_op(1, 32'h0000_1234, 32'd0, 1'b0, -1, "div_zero_u");
    run_op(1, 32'hFFFF_0000, 32'd0, 1'b1, -1, "div_zero_s");
    run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, "signed_overflow");
  endtask

  task automatic test_flush;
    run_op(1, 32'd100, 32'd7, 1'b0, 10, "flush_cyc10");
    @(negedge clk);
    run_op(1, 32'd9, 32'd3, 1'b0, -1, "after_flush_9_3");
    run_op(1, 32'd50, 32'd6, 1'b0, 33, "flush_in_done");
    run_op(1, 32'd5, 32'd0, 1'b0, 1, "flush_div_zero_done");
  endtask

  task automatic test_back_to_back;
    run_op(2, 32'hFFFF_FFFF, 32'h0000_0010, 1'b0, -1, "bpc2_max_16");
    run_op(2, 32'd1, 32'd1, 1'b0, -1, "bpc2_b2b_1_1");
    run_op(2, 32'hFFFF_FFF9, 32'd2, 1'b1, -1, "bpc2_signed_m7_2");
    run_op(2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, "bpc2_overflow");
  endtask

  task automatic test_reset_mid;
    set_in(1, 1'b1, 1'b0, 1'b0, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    set_in(1, 1'b0, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (get_q(1) !== 32'd0 || get_r(1) !== 32'd0 || get_busy(1) !== 1'b0 || get_done(1) !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: q=%h r=%h busy=%b done=%b required all 0", get_q(1), get_r(1),
               get_busy(1), get_done(1));
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    logic        s;
    int          fl;
    for (int sel = 1; sel <= 2; sel++) begin
      for (int n = 0; n < 400; n++) begin
        a = $urandom;
        b = $urandom;
        s = 1'($urandom);
        case ($urandom_range(0, 5))
          0: b = $urandom_range(0, 15);
          1: b = 32'hFFFF_FFFF;
          2: a = 32'h8000_0000;
          3: b = b >> $urandom_range(0, 31);
          default: ;
        endcase
        fl = ($urandom_range(0, 9) == 0) ? $urandom_range(1, (sel == 1) ? 33 : 17) : -1;
        if (b == 32'd0 && fl > 1) fl = -1;
        run_op(sel, a, b, s, fl, "random");
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_corner();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
